mon_frame_receiver: RTL and testbench

- Deserialises the monitor-bus serial input `to_mon` into 40-bit frames, in the `mon_clk` domain.
- Stage directly upstream of the frame consumers (debug data sender, future sound/keyboard decoders). It is the mirror of the existing Sender path.
- Presents each frame as parallel `in_data` with a one-cycle `data_recv` strobe.
- Flags malformed frames and re-arms only after the line has been idle long enough.

---
 rtl/mon_pkg.sv | 18 +
 rtl/mon_line_idle_detect.sv | 35 +++
 rtl/mon_frame_receiver.sv | 106 ++++++++++
 tb/tb_mon_frame_receiver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mon_pkg.sv
// Shared monitor-bus definitions: frame geometry, line levels and receiver states.
// Used by both the receiver and the sender.
package mon_pkg;

   localparam int MON_DATA_WIDTH = 40;
   localparam int MON_IDLE_MIN   = 4;

   localparam logic MON_START_BIT = 1'b0;
   localparam logic MON_STOP_BIT  = 1'b1;

   typedef enum logic [1:0] {
      RESYNC,
      IDLE,
      DATA,
      STOP
   } mon_rx_state_t;

endpackage

// File: rtl/mon_line_idle_detect.sv
// Purpose: registers the serial line and counts consecutive idle-high samples.
// Latency: line_q lags to_mon by one cycle; armed is combinational from registers.
// Backpressure: none, free-running sampler.
module mon_line_idle_detect
   import mon_pkg::*;
#(
   parameter int IDLE_MIN = MON_IDLE_MIN
) (
   input  logic mon_clk,
   input  logic reset,
   input  logic to_mon,
   output logic line_q,
   output logic armed
);

   logic [3:0] idle_cnt;

   always_ff @(posedge mon_clk) begin
      if (reset) begin
         line_q   <= 1'b1;
         idle_cnt <= '0;
      end else begin
         line_q <= to_mon;
         if (line_q != MON_STOP_BIT)
            idle_cnt <= '0;
         else if (idle_cnt != 4'hF)
            idle_cnt <= idle_cnt + 4'd1;
      end
   end

   // Counts the high sample currently in line_q, so the FSM reaches IDLE
   // in time to catch a start bit right after the last required high.
   assign armed = (line_q == MON_STOP_BIT) && (idle_cnt >= 4'(IDLE_MIN - 1));

endmodule

// File: rtl/mon_frame_receiver.sv
// Purpose: deserialises 40-bit monitor-bus frames; MON_RX_ERR_CNT_EN adds err_count.
// Latency: data_recv/in_data appear two cycles after the stop bit is sampled on to_mon.
// Backpressure: none, consumers must accept each data_recv pulse.
module mon_frame_receiver
   import mon_pkg::*;
#(
   parameter int DATA_WIDTH = MON_DATA_WIDTH,
   parameter int IDLE_MIN   = MON_IDLE_MIN
) (
   input  logic                  mon_clk,
   input  logic                  reset,
   input  logic                  to_mon,
   output logic [DATA_WIDTH-1:0] in_data,
   output logic                  data_recv,
   output logic                  frame_err,
   output logic                  busy
`ifdef MON_RX_ERR_CNT_EN
   ,
   output logic [7:0]            err_count
`endif
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   mon_rx_state_t         state, state_nxt;
   logic                  line_q, armed;
   logic [DATA_WIDTH-1:0] shift;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  good_nxt, bad_nxt;
   logic                  good_q, bad_q;

   mon_line_idle_detect #(.IDLE_MIN(IDLE_MIN)) u_idle (
      .mon_clk (mon_clk),
      .reset   (reset),
      .to_mon  (to_mon),
      .line_q  (line_q),
      .armed   (armed)
   );

   always_ff @(posedge mon_clk) begin
      if (reset)
         state <= RESYNC;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      good_nxt  = 1'b0;
      bad_nxt   = 1'b0;
      case (state)
         RESYNC: if (armed) state_nxt = IDLE;
         IDLE:   if (line_q == MON_START_BIT) state_nxt = DATA;
         DATA:   if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) state_nxt = STOP;
         STOP: begin
            if (line_q == MON_STOP_BIT) begin
               good_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               bad_nxt   = 1'b1;
               state_nxt = RESYNC;
            end
         end
         default: state_nxt = RESYNC;
      endcase
   end

   // The stop verdict is held one cycle before publishing; shift is still
   // intact then because a back-to-back frame only starts shifting a cycle later.
   always_ff @(posedge mon_clk) begin
      if (reset) begin
         shift     <= '0;
         bit_cnt   <= '0;
         good_q    <= 1'b0;
         bad_q     <= 1'b0;
         in_data   <= '0;
         data_recv <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         good_q    <= good_nxt;
         bad_q     <= bad_nxt;
         data_recv <= good_q;
         frame_err <= bad_q;
         if (good_q)
            in_data <= shift;
         busy <= (state_nxt == DATA) || (state_nxt == STOP) || (state == STOP);
         if (state == IDLE) begin
            bit_cnt <= '0;
         end else if (state == DATA) begin
            shift   <= {shift[DATA_WIDTH-2:0], line_q};
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

`ifdef MON_RX_ERR_CNT_EN
   always_ff @(posedge mon_clk) begin
      if (reset)
         err_count <= '0;
      else if (bad_q && (err_count != 8'hFF))
         err_count <= err_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_mon_frame_receiver.sv
// Directed bench for mon_frame_receiver: framing, latency, back-to-back,
// framing-error resync, reset mid-frame and stuck-low line.
module tb_mon_frame_receiver;
   import mon_pkg::*;

   localparam int DW = MON_DATA_WIDTH;

   logic          mon_clk = 1'b0;
   logic          reset   = 1'b1;
   logic          to_mon  = 1'b1;
   logic [DW-1:0] in_data;
   logic          data_recv, frame_err, busy;
`ifdef MON_RX_ERR_CNT_EN
   logic [7:0]    err_count;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 mon_clk = ~mon_clk;
   always @(posedge mon_clk) cyc <= cyc + 1;

   mon_frame_receiver dut (
      .mon_clk   (mon_clk),
      .reset     (reset),
      .to_mon    (to_mon),
      .in_data   (in_data),
      .data_recv (data_recv),
      .frame_err (frame_err),
      .busy      (busy)
`ifdef MON_RX_ERR_CNT_EN
      ,
      .err_count (err_count)
`endif
   );

   // Output monitor, sampled on the falling edge.
   int            n_recv = 0, n_err = 0, n_overlap = 0;
   int            last_recv_cyc = 0, last_err_cyc = 0;
   int            busy_run = 0, last_busy_run = 0, busy_cycles = 0;
   int            recv_cyc_q[$];
   logic [DW-1:0] recv_dat_q[$];

   always @(negedge mon_clk) begin
      if (data_recv) begin
         n_recv++;
         last_recv_cyc = cyc;
         recv_cyc_q.push_back(cyc);
         recv_dat_q.push_back(in_data);
      end
      if (frame_err) begin
         n_err++;
         last_err_cyc = cyc;
      end
      if (data_recv && frame_err) n_overlap++;
      if (busy) begin
         busy_run++;
         busy_cycles++;
      end else if (busy_run != 0) begin
         last_busy_run = busy_run;
         busy_run = 0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   int stop_edge;

   task automatic drive(input logic b);
      to_mon = b;
      @(posedge mon_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1);
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic stop);
      drive(MON_START_BIT);
      for (int i = DW - 1; i >= 0; i--) drive(d[i]);
      drive(stop);
      stop_edge = cyc;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   int            n0, m0, bc0, e, e1, e2;
   logic [DW-1:0] pf;

   initial begin
      // Reset state
      reset  = 1'b1;
      to_mon = 1'b1;
      @(posedge mon_clk);
      @(posedge mon_clk);
      #1;
      reset = 1'b0;
      chk("rst_in_data", in_data, 0);
      chk("rst_data_recv", data_recv, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_busy", busy, 0);

      // Single frame after four idle highs
      idle(4);
      n0 = n_recv;
      send_frame(40'hA5_1234_5678, 1'b1);
      e = stop_edge;
      idle(3);
      chk("f1_count", n_recv - n0, 1);
      chk("f1_latency", last_recv_cyc, e + 2);
      chk("f1_data", in_data, 40'hA512345678);
      chk("f1_busy_len", last_busy_run, 42);
      chk("f1_no_err", n_err, 0);

      // Back-to-back frames, zero idle gap
      n0 = n_recv;
      recv_cyc_q.delete();
      recv_dat_q.delete();
      send_frame(40'h00_0000_0001, 1'b1);
      e1 = stop_edge;
      send_frame(40'hFF_FFFF_FFFE, 1'b1);
      e2 = stop_edge;
      idle(3);
      chk("b2b_count", n_recv - n0, 2);
      if (recv_dat_q.size() == 2) begin
         chk("b2b_data0", recv_dat_q[0], 40'h0000000001);
         chk("b2b_data1", recv_dat_q[1], 40'hFFFFFFFFFE);
         chk("b2b_lat0", recv_cyc_q[0], e1 + 2);
         chk("b2b_gap", recv_cyc_q[1] - recv_cyc_q[0], e2 - e1);
         chk("b2b_gap42", e2 - e1, 42);
      end

      // Framing error, short idle ignored, full idle accepted
      n0 = n_recv;
      m0 = n_err;
      send_frame(40'h12_3456_789A, 1'b0);
      e = stop_edge;
      idle(2);
      bc0 = busy_cycles;
      for (int i = 0; i < 10; i++) drive(1'b0);
      chk("err_count", n_err - m0, 1);
      chk("err_latency", last_err_cyc, e + 2);
      chk("err_hold_data", in_data, 40'hFFFFFFFFFE);
      chk("err_no_recv", n_recv - n0, 0);
      chk("ign_busy", busy_cycles - bc0, 0);
      idle(4);
      send_frame(40'hC3_0FF0_3C96, 1'b1);
      idle(3);
      chk("resync_count", n_recv - n0, 1);
      chk("resync_data", in_data, 40'hC30FF03C96);
      chk("resync_err", n_err - m0, 1);

      // Reset at data bit 20
      n0 = n_recv;
      m0 = n_err;
      pf = 40'h11_1111_1111;
      drive(MON_START_BIT);
      for (int i = DW - 1; i >= DW - 20; i--) drive(pf[i]);
      reset = 1'b1;
      @(posedge mon_clk);
      #1;
      reset = 1'b0;
      chk("midrst_in_data", in_data, 0);
      idle(4);
      send_frame(40'hDE_ADBE_EF01, 1'b1);
      idle(3);
      chk("midrst_count", n_recv - n0, 1);
      chk("midrst_data", in_data, 40'hDEADBEEF01);
      chk("midrst_no_err", n_err - m0, 0);

      // Line low through and after reset
      reset  = 1'b1;
      to_mon = 1'b0;
      @(posedge mon_clk);
      #1;
      reset = 1'b0;
      n0  = n_recv;
      m0  = n_err;
      bc0 = busy_cycles;
      for (int i = 0; i < 100; i++) drive(1'b0);
      chk("low_no_recv", n_recv - n0, 0);
      chk("low_no_err", n_err - m0, 0);
      chk("low_no_busy", busy_cycles - bc0, 0);
      idle(4);
      send_frame(40'h0F_1E2D_3C4B, 1'b1);
      idle(3);
      chk("low_then_count", n_recv - n0, 1);
      chk("low_then_data", in_data, 40'h0F1E2D3C4B);

`ifdef MON_RX_ERR_CNT_EN
      for (int k = 0; k < 300; k++) begin
         idle(4);
         send_frame(40'h01_2345_6789, 1'b0);
      end
      idle(4);
      chk("errcnt_sat", err_count, 8'hFF);
      reset = 1'b1;
      to_mon = 1'b1;
      @(posedge mon_clk);
      #1;
      reset = 1'b0;
      chk("errcnt_rst", err_count, 0);
`endif

      chk("no_overlap", n_overlap, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
